// File: rtl/pong_pkg.sv
// Shared definitions for the Pong ball engine: state codes, direction
// encoding and default grid/game constants.
package pong_pkg;

  localparam int unsigned W_X_DEF        = 8;
  localparam int unsigned H_Y_DEF        = 8;
  localparam int unsigned RAQ_LARG_DEF   = 2;
  localparam int unsigned PONTOS_W_DEF   = 3;
  localparam int unsigned PONTOS_VIT_DEF = 5;
  localparam int unsigned VIDAS_DEF      = 3;

  localparam int unsigned EST_W = 3;

  typedef enum logic [EST_W-1:0] {
    ESPERA = 3'd0,
    JOGO   = 3'd1,
    FALTA  = 3'd2,
    PERDEU = 3'd3,
    GANHOU = 3'd4
  } estado_t;

  // Direction bit: 0 = moving toward higher index, 1 = toward lower index.
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/detector_raquete.sv
// Combinational paddle hit detector for one paddle.
// Ports:
//   posx       - current ball column
//   vx         - horizontal direction after the wall rule
//   raquete    - leftmost paddle column
//   hit_direto - ball column lies inside the paddle span
//   hit_canto  - ball is outside the span but its next column is inside
module detector_raquete
  import pong_pkg::*;
#(
  parameter  int unsigned W_X      = W_X_DEF,
  parameter  int unsigned RAQ_LARG = RAQ_LARG_DEF,
  localparam int unsigned XW       = $clog2(W_X)
) (
  input  logic [XW-1:0] posx,
  input  logic          vx,
  input  logic [XW-1:0] raquete,
  output logic          hit_direto,
  output logic          hit_canto
);

  localparam logic [XW:0] LARG_M1 = (XW+1)'(RAQ_LARG - 1);
  localparam logic [XW:0] X_MAX_E = (XW+1)'(W_X - 1);

  logic [XW:0] lim_lo;
  logic [XW:0] soma;
  logic [XW:0] lim_hi;
  logic [XW:0] x_ext;
  logic [XW:0] x_prox;
  logic        prox_ok;

  // Span computed one bit wider so the right end saturates instead of wrapping.
  always_comb begin
    lim_lo  = {1'b0, raquete};
    soma    = lim_lo + LARG_M1;
    lim_hi  = (soma > X_MAX_E) ? X_MAX_E : soma;
    x_ext   = {1'b0, posx};
    prox_ok = 1'b1;
    if (vx == DIR_POS) begin
      x_prox = x_ext + 1'b1;
      if (x_ext == X_MAX_E) prox_ok = 1'b0;
    end else begin
      x_prox = x_ext - 1'b1;
      if (x_ext == '0) prox_ok = 1'b0;
    end
    hit_direto = (x_ext >= lim_lo) && (x_ext <= lim_hi);
    hit_canto  = !hit_direto && prox_ok && (x_prox >= lim_lo) && (x_prox <= lim_hi);
  end

endmodule

// File: rtl/controle_bola.sv
// Pong ball engine: ball position/direction, wall and paddle collisions,
// score, lives and the serve/miss/game-over state machine. Advances once
// per tick strobe.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   tick                  - one-cycle advance strobe
//   saque                 - serve request (used on tick in ESPERA)
//   raquete_cima/_baixo   - leftmost column of top / bottom paddle
//   posx, posy            - ball position
//   pontos, vidas         - score and remaining lives
//   estado                - state code
//   colisao               - one-cycle paddle-hit pulse
//   perdeu, ganhou        - decoded terminal states
// Build option: SAQUE_AUTO_EN enables automatic serve on the 4th tick in ESPERA.
module controle_bola
  import pong_pkg::*;
#(
  parameter  int unsigned W_X        = W_X_DEF,
  parameter  int unsigned H_Y        = H_Y_DEF,
  parameter  int unsigned RAQ_LARG   = RAQ_LARG_DEF,
  parameter  int unsigned PONTOS_W   = PONTOS_W_DEF,
  parameter  int unsigned PONTOS_VIT = PONTOS_VIT_DEF,
  parameter  int unsigned VIDAS      = VIDAS_DEF,
  localparam int unsigned XW         = $clog2(W_X),
  localparam int unsigned YW         = $clog2(H_Y)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                saque,
  input  logic [XW-1:0]       raquete_cima,
  input  logic [XW-1:0]       raquete_baixo,
  output logic [XW-1:0]       posx,
  output logic [YW-1:0]       posy,
  output logic [PONTOS_W-1:0] pontos,
  output logic [2:0]          vidas,
  output logic [EST_W-1:0]    estado,
  output logic                colisao,
  output logic                perdeu,
  output logic                ganhou
);

  localparam logic [XW-1:0]       X_MAX  = XW'(W_X - 1);
  localparam logic [XW-1:0]       X_CENT = XW'(W_X / 2);
  localparam logic [YW-1:0]       Y_MAX  = YW'(H_Y - 1);
  localparam logic [YW-1:0]       Y_CENT = YW'(H_Y / 2);
  localparam logic [YW-1:0]       Y_TOPO = YW'(H_Y - 2);
  localparam logic [YW-1:0]       Y_BASE = YW'(1);
  localparam logic [PONTOS_W-1:0] P_MAX  = '1;
  localparam logic [PONTOS_W-1:0] P_VIT  = PONTOS_W'(PONTOS_VIT);
  localparam logic [2:0]          V_INI  = 3'(VIDAS);

  estado_t               estado_q, estado_n;
  logic                  vx_q, vx_n, vy_q, vy_n;
  logic                  paridade_q, paridade_n;
  logic [XW-1:0]         posx_n;
  logic [YW-1:0]         posy_n;
  logic [PONTOS_W-1:0]   pontos_n, pontos_inc;
  logic [2:0]            vidas_n;
  logic                  colisao_n;

  logic                  parede, vx_w;
  logic                  cima_direto, cima_canto, baixo_direto, baixo_canto;
  logic                  toque_topo, toque_base, hit_dir, hit_can, hit;
  logic                  vx_j, vy_j;
  logic [YW-1:0]         posy_j;
  logic                  serve_c;

  // Wall rule runs first; the paddle detectors see the post-wall direction.
  assign parede = ((posx == X_MAX) && (vx_q == DIR_POS)) ||
                  ((posx == '0)    && (vx_q == DIR_NEG));
  assign vx_w   = parede ? ~vx_q : vx_q;

  detector_raquete #(.W_X(W_X), .RAQ_LARG(RAQ_LARG)) u_det_cima (
    .posx       (posx),
    .vx         (vx_w),
    .raquete    (raquete_cima),
    .hit_direto (cima_direto),
    .hit_canto  (cima_canto)
  );

  detector_raquete #(.W_X(W_X), .RAQ_LARG(RAQ_LARG)) u_det_baixo (
    .posx       (posx),
    .vx         (vx_w),
    .raquete    (raquete_baixo),
    .hit_direto (baixo_direto),
    .hit_canto  (baixo_canto)
  );

  assign toque_topo = (posy == Y_TOPO) && (vy_q == DIR_POS);
  assign toque_base = (posy == Y_BASE) && (vy_q == DIR_NEG);
  assign hit_dir    = (toque_topo && cima_direto) || (toque_base && baixo_direto);
  assign hit_can    = (toque_topo && cima_canto)  || (toque_base && baixo_canto);
  assign hit        = hit_dir || hit_can;

`ifdef SAQUE_AUTO_EN
  logic [1:0] cnt_q, cnt_n;

  assign serve_c = saque || (cnt_q == 2'd3);

  // Counts ticks spent in ESPERA; cleared everywhere else.
  always_comb begin
    cnt_n = '0;
    if (estado_q == ESPERA) begin
      cnt_n = cnt_q;
      if (tick) cnt_n = serve_c ? 2'd0 : cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_n;
  end
`else
  assign serve_c = saque;
`endif

  // Next-state and datapath update.
  always_comb begin
    estado_n   = estado_q;
    posx_n     = posx;
    posy_n     = posy;
    vx_n       = vx_q;
    vy_n       = vy_q;
    pontos_n   = pontos;
    vidas_n    = vidas;
    paridade_n = paridade_q;
    colisao_n  = 1'b0;
    vx_j       = vx_w;
    vy_j       = vy_q;
    posy_j     = posy;
    pontos_inc = (pontos == P_MAX) ? pontos : pontos + 1'b1;

    if (tick) begin
      case (estado_q)
        ESPERA: begin
          posx_n = X_CENT;
          posy_n = Y_CENT;
          if (serve_c) begin
            estado_n   = JOGO;
            vx_n       = DIR_POS;
            vy_n       = paridade_q ? DIR_NEG : DIR_POS;
            paridade_n = ~paridade_q;
          end
        end

        JOGO: begin
          if (hit) vy_j = ~vy_q;
          // Corner hit bounces sideways only when that keeps the ball on the grid.
          if (hit_can && !(((vx_w == DIR_POS) && (posx == '0)) ||
                           ((vx_w == DIR_NEG) && (posx == X_MAX))))
            vx_j = ~vx_w;
          posx_n = (vx_j == DIR_POS) ? posx + 1'b1 : posx - 1'b1;
          posy_j = (vy_j == DIR_POS) ? posy + 1'b1 : posy - 1'b1;
          posy_n = posy_j;
          vx_n   = vx_j;
          vy_n   = vy_j;
          if (hit) begin
            pontos_n  = pontos_inc;
            colisao_n = 1'b1;
          end
          if (hit && (pontos_inc == P_VIT)) begin
            estado_n = GANHOU;
          end else if ((posy_j == '0) || (posy_j == Y_MAX)) begin
            estado_n = FALTA;
            vidas_n  = (vidas == '0) ? vidas : vidas - 1'b1;
          end
        end

        FALTA: begin
          if (vidas == '0) begin
            estado_n = PERDEU;
          end else begin
            estado_n = ESPERA;
            posx_n   = X_CENT;
            posy_n   = Y_CENT;
            vx_n     = DIR_POS;
          end
        end

        default: begin
          // PERDEU and GANHOU hold everything until reset.
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= ESPERA;
      posx       <= X_CENT;
      posy       <= Y_CENT;
      vx_q       <= DIR_POS;
      vy_q       <= DIR_POS;
      pontos     <= '0;
      vidas      <= V_INI;
      paridade_q <= 1'b0;
      colisao    <= 1'b0;
    end else begin
      estado_q   <= estado_n;
      posx       <= posx_n;
      posy       <= posy_n;
      vx_q       <= vx_n;
      vy_q       <= vy_n;
      pontos     <= pontos_n;
      vidas      <= vidas_n;
      paridade_q <= paridade_n;
      colisao    <= colisao_n;
    end
  end

  assign estado = estado_q;
  assign perdeu = (estado_q == PERDEU);
  assign ganhou = (estado_q == GANHOU);

endmodule

// File: tb/tb_controle_bola.sv
// Directed bench for controle_bola with default parameters.
module tb_controle_bola;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       saque;
  logic [2:0] raquete_cima;
  logic [2:0] raquete_baixo;
  logic [2:0] posx;
  logic [2:0] posy;
  logic [2:0] pontos;
  logic [2:0] vidas;
  logic [2:0] estado;
  logic       colisao;
  logic       perdeu;
  logic       ganhou;

  int n_chk  = 0;
  int n_fail = 0;

  controle_bola dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .saque         (saque),
    .raquete_cima  (raquete_cima),
    .raquete_baixo (raquete_baixo),
    .posx          (posx),
    .posy          (posy),
    .pontos        (pontos),
    .vidas         (vidas),
    .estado        (estado),
    .colisao       (colisao),
    .perdeu        (perdeu),
    .ganhou        (ganhou)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    chk({tag, ".posx"}, 32'(posx), 32'(x));
    chk({tag, ".posy"}, 32'(posy), 32'(y));
  endtask

  task automatic chk_game(input string tag, input int e, input int p, input int v, input int c);
    chk({tag, ".estado"},  32'(estado),  32'(e));
    chk({tag, ".pontos"},  32'(pontos),  32'(p));
    chk({tag, ".vidas"},   32'(vidas),   32'(v));
    chk({tag, ".colisao"}, 32'(colisao), 32'(c));
  endtask

  // Hold tick high for n consecutive cycles; returns on the falling edge after the last.
  task automatic ticks(input int n);
    @(negedge clk);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; saque = 1'b0;
    raquete_cima = 3'd0; raquete_baixo = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset values
    chk_pos("rst", 4, 4);
    chk_game("rst", 0, 0, 3, 0);
    chk("rst.perdeu", 32'(perdeu), 0);
    chk("rst.ganhou", 32'(ganhou), 0);

    // saque without tick does nothing
    saque = 1'b1;
    repeat (3) @(negedge clk);
    saque = 1'b0;
    chk("notick.estado", 32'(estado), 0);

    // Auto-serve window
    ticks(3);
    chk("auto3.estado", 32'(estado), 0);
    ticks(1);
`ifdef SAQUE_AUTO_EN
    chk("auto4.estado", 32'(estado), 1);
`else
    chk("auto4.estado", 32'(estado), 0);
`endif
    chk_pos("auto4", 4, 4);
    do_reset();

    // ---- Game to victory ----
    saque = 1'b1; ticks(1); saque = 1'b0;
    chk("serve.estado", 32'(estado), 1);
    chk_pos("serve", 4, 4);
    ticks(1); chk_pos("mv1", 5, 5);
    ticks(1); chk_pos("mv2", 6, 6);
    raquete_cima = 3'd5;
    ticks(1);
    chk_pos("hit1", 7, 5);
    chk_game("hit1", 1, 1, 3, 1);
    raquete_cima = 3'd0;
    @(negedge clk);
    chk("hit1.pulse_end", 32'(colisao), 0);
    chk_pos("hold", 7, 5);
    ticks(4); chk_pos("wall", 3, 1);
    raquete_baixo = 3'd1;
    ticks(1);
    chk_pos("corner", 4, 2);
    chk_game("corner", 1, 2, 3, 1);
    ticks(4); chk_pos("mv3", 6, 6);
    raquete_cima = 3'd6;
    ticks(1);
    chk_pos("hit3", 5, 5);
    chk("hit3.pontos", 32'(pontos), 3);
    ticks(4); chk_pos("mv4", 1, 1);
    raquete_baixo = 3'd0;
    ticks(1);
    chk_pos("hit4", 0, 2);
    chk("hit4.pontos", 32'(pontos), 4);
    ticks(4); chk_pos("mv5", 4, 6);
    raquete_cima = 3'd5;
    ticks(1);
    chk_pos("win", 3, 5);
    chk_game("win", 4, 5, 3, 1);
    chk("win.ganhou", 32'(ganhou), 1);
    saque = 1'b1; ticks(3); saque = 1'b0;
    chk_pos("win_frz", 3, 5);
    chk_game("win_frz", 4, 5, 3, 0);

    // ---- Game to defeat ----
    do_reset();
    raquete_cima = 3'd0; raquete_baixo = 3'd0;
    saque = 1'b1; ticks(1); saque = 1'b0;
    ticks(2); chk_pos("g2.mv", 6, 6);
    ticks(1);
    chk_pos("miss1", 7, 7);
    chk_game("miss1", 2, 0, 2, 0);
    @(negedge clk);
    chk_pos("miss1_hold", 7, 7);
    ticks(1);
    chk_pos("recenter1", 4, 4);
    chk("recenter1.estado", 32'(estado), 0);
    saque = 1'b1; ticks(1); saque = 1'b0;
    ticks(3); chk_pos("serve2_down", 7, 1);
    raquete_baixo = 3'd7;
    ticks(1);
    chk_pos("edge_hit", 6, 2);
    chk_game("edge_hit", 1, 1, 2, 1);
    ticks(4); chk_pos("mv6", 2, 6);
    raquete_cima = 3'd5;
    ticks(1);
    chk_pos("miss2", 1, 7);
    chk_game("miss2", 2, 1, 1, 0);
    ticks(1);
    chk_pos("recenter2", 4, 4);
    raquete_cima = 3'd0;
    saque = 1'b1; ticks(1); saque = 1'b0;
    ticks(2); chk_pos("serve3", 6, 6);
    ticks(1);
    chk_game("miss3", 2, 1, 0, 0);
    ticks(1);
    chk_game("lost", 3, 1, 0, 0);
    chk("lost.perdeu", 32'(perdeu), 1);
    chk_pos("lost", 7, 7);
    saque = 1'b1; ticks(3); saque = 1'b0;
    chk_game("lost_frz", 3, 1, 0, 0);
    chk_pos("lost_frz", 7, 7);

    // ---- Reset mid-JOGO, concurrent with tick ----
    do_reset();
    saque = 1'b1; ticks(1); saque = 1'b0;
    ticks(2);
    raquete_cima = 3'd5;
    ticks(1);
    chk("g3.pontos", 32'(pontos), 1);
    @(negedge clk);
    reset = 1'b1; tick = 1'b1;
    @(negedge clk);
    reset = 1'b0; tick = 1'b0;
    chk_pos("midrst", 4, 4);
    chk_game("midrst", 0, 0, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_bola.md
# controle_bola

Parametrised ball engine for the FPGA Pong game. It holds ball position and direction on a configurable W_X×H_Y LED grid and resolves wall and paddle collisions. It tracks score and lives and sequences serve, miss and game-over through a state machine. It sits between the paddle-position registers and the matrix display driver, and advances one step per `tick` strobe from the game-speed divider.

## Interface
- W_X, 8, grid columns (≥4); XW = $clog2(W_X)
- H_Y, 8, grid rows (≥4); YW = $clog2(H_Y)
- RAQ_LARG, 2, paddle width in columns (1..W_X)
- PONTOS_W, 3, score counter width
- PONTOS_VIT, 5, score that wins the game (< 2^PONTOS_W)
- VIDAS, 3, lives at reset (1..7)
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high; sampled on rising `clk`
- tick  in  1  one-cycle advance strobe
- saque  in  1  serve request, sampled only when `tick`=1 in ESPERA
- raquete_cima  in  XW  leftmost column of the top paddle (row H_Y-1)
- raquete_baixo  in  XW  leftmost column of the bottom paddle (row 0)
- posx  out  XW  ball column
- posy  out  YW  ball row
- pontos  out  PONTOS_W  paddle hits this game
- vidas  out  3  remaining lives
- estado  out  3  FSM state code
- colisao  out  1  one-cycle pulse on a paddle hit
- perdeu  out  1  high in state PERDEU
- ganhou  out  1  high in state GANHOU

## Operation
- Reset: posx=W_X/2, posy=H_Y/2, vx=+1, vy=+1, pontos=0, vidas=VIDAS, estado=ESPERA, colisao=0, serve-parity=0.
- Paddle span is [p, min(p+RAQ_LARG-1, W_X-1)]. Compute it in XW+1 bits. It saturates at the edge and never wraps.
- The FSM acts only on cycles with tick=1. All other cycles hold state.
- ESPERA: the ball is parked at the centre. saque=1 → JOGO with vx=+1. vy=+1 if serve-parity=0, otherwise -1. Serve-parity toggles on each serve.
- JOGO: one tick performs the following steps in order, all in a single cycle.
  - Wall: if posx=W_X-1 with vx=+1, or posx=0 with vx=-1, then vx flips.
  - Paddle: applies if posy=H_Y-2 with vy=+1 (top paddle), or posy=1 with vy=-1 (bottom paddle).
    - posx in span: vy flips.
    - posx outside span but posx+vx in span (corner): vy flips, and vx also flips unless the flip would leave the grid.
    - Either case: pontos+1 and colisao=1.
  - Move: posx+=vx, posy+=vy using the updated vectors.
  - If the new posy is 0 or H_Y-1 → FALTA, and vidas decrements.
  - If pontos reaches PONTOS_VIT → GANHOU. This takes priority over every other transition on that tick.
- FALTA: the ball stays on the edge row for one tick. On the next tick: vidas=0 → PERDEU; otherwise → ESPERA with the ball re-centred and vx=+1.
- PERDEU / GANHOU: terminal states. Position, score and lives freeze. Only reset exits.
- Arithmetic: position never wraps; the wall rule guarantees bounds. pontos saturates at 2^PONTOS_W-1.

## Timing
- Every output is registered except perdeu and ganhou, which decode the registered `estado`.
- Latency: the effect of a tick is visible one cycle after the tick edge.
- colisao is high exactly for the cycle after the hitting tick.
- tick held high advances the engine every cycle. Back-to-back ticks are legal.
- Paddle inputs are sampled on the tick edge only. Changes between ticks have no effect.
- Reset has priority over tick. Reset asserted in any state, including mid-FALTA, restores the reset values on the next edge.
- State codes: ESPERA=0, JOGO=1, FALTA=2, PERDEU=3, GANHOU=4.

## Configuration
- SAQUE_AUTO_EN
  - Defined: a 2-bit counter runs in ESPERA, and the 4th tick in ESPERA serves automatically even with saque=0. saque still serves immediately. The counter clears on leaving ESPERA.
  - Undefined: a serve happens only through saque. No counter is synthesised.

## Structure
- Shared package `pong_pkg` holds:
  - the state encoding constants (ESPERA..GANHOU);
  - the direction constants DIR_POS/DIR_NEG;
  - the default grid constants.
- One sub-module, `detector_raquete` (combinational): inputs posx, vx and paddle column; outputs hit_direto and hit_canto. It is instantiated once per paddle.

## Test plan
All scenarios use default parameters.
- Reset, then tick with saque=1 → estado=1. Next two ticks, raquete_cima=0 → (5,5), then (6,6).
- From (6,6) with vx=+1, vy=+1 and raquete_cima=5 → tick gives (7,5), pontos=1, colisao pulse, vy=-1.
- Miss: from (6,6) with raquete_cima=0 → (7,7), estado=2, vidas=2. Next tick → estado=0 with the ball at (4,4).
- Three misses → estado=3, perdeu=1. Further ticks with saque=1 leave all outputs unchanged.
- Fifth hit → estado=4, ganhou=1, pontos=5, no FALTA taken. Reset asserted mid-JOGO → (4,4), pontos=0, vidas=3 next cycle.
- SAQUE_AUTO_EN defined: after reset, 4 ticks with saque=0 → estado=1. Undefined: estado stays 0.
